// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: register file, forwarding record, retire counter, halt FSM
//
// Purpose:
//   Consumes the MEM latch. Owns the 32-entry architectural register file
//   (x0 reads as zero) and serves two combinational read ports to decode with
//   a same-cycle write-through bypass. Publishes the current write to decode
//   and a one-cycle-delayed write record to AGEX. Counts retired instructions
//   and freezes architectural state once a halt instruction retires.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   mem_*                 MEM latch: valid, pc, op, inst_count, wr_reg, rd,
//                         regval, is_halt
//   rs1_idx/rs2_idx       decode read indices
//   rs1_val/rs2_val       decode read data (combinational)
//   wb_to_de_we/_rd       register write happening this cycle
//   fwd_valid/_rd/_val    registered record of the previous cycle's write
//   retired_count         instructions retired since reset (wraps)
//   halted                halt state machine is in HALTED
//   last_pc               PC of the most recently retired instruction
module wb_stage #(
  parameter int DBITS      = 32,
  parameter int REGNOBITS  = 5,
  parameter int IOPBITS    = 6,
  parameter int TYPENOBITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [DBITS-1:0]     mem_pc,
  input  logic [IOPBITS-1:0]   mem_op,
  input  logic [DBITS-1:0]     mem_inst_count,
  input  logic                 mem_wr_reg,
  input  logic [REGNOBITS-1:0] mem_rd,
  input  logic [DBITS-1:0]     mem_regval,
  input  logic                 mem_is_halt,
  input  logic [REGNOBITS-1:0] rs1_idx,
  input  logic [REGNOBITS-1:0] rs2_idx,
  output logic [DBITS-1:0]     rs1_val,
  output logic [DBITS-1:0]     rs2_val,
  output logic                 wb_to_de_we,
  output logic [REGNOBITS-1:0] wb_to_de_rd,
  output logic                 fwd_valid,
  output logic [REGNOBITS-1:0] fwd_rd,
  output logic [DBITS-1:0]     fwd_val,
  output logic [DBITS-1:0]     retired_count,
  output logic                 halted,
  output logic [DBITS-1:0]     last_pc
);

  localparam int NREGS = 1 << REGNOBITS;

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]           r_state;
  logic [DBITS-1:0]     r_rf [NREGS];
  logic [DBITS-1:0]     r_retired_count;
  logic [DBITS-1:0]     r_last_pc;
  logic                 r_fwd_valid;
  logic [REGNOBITS-1:0] r_fwd_rd;
  logic [DBITS-1:0]     r_fwd_val;

  logic w_run;
  logic w_retire;
  logic w_we;

  // Opcode and fetch sequence number travel with the instruction for trace
  // only; they never influence architectural state.
  logic w_trace_unused;
  assign w_trace_unused = ^{mem_op, mem_inst_count};

  assign w_run    = (r_state == S_RUN);
  assign w_retire = mem_valid & w_run;
  // Writes to x0 are dropped entirely, so decode never sees a hazard on x0.
  assign w_we     = w_retire & mem_wr_reg & (mem_rd != '0);

  assign wb_to_de_we = w_we;
  assign wb_to_de_rd = mem_rd;

  // Bypass lets decode see a value in the same cycle it is being written.
  always_comb begin
    rs1_val = r_rf[rs1_idx];
    if (rs1_idx == '0)
      rs1_val = '0;
    else if (w_we && (rs1_idx == mem_rd))
      rs1_val = mem_regval;
  end

  always_comb begin
    rs2_val = r_rf[rs2_idx];
    if (rs2_idx == '0)
      rs2_val = '0;
    else if (w_we && (rs2_idx == mem_rd))
      rs2_val = mem_regval;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else if (w_we) begin
      r_rf[mem_rd] <= mem_regval;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_RUN;
      r_retired_count <= '0;
      r_last_pc       <= '0;
      r_fwd_valid     <= 1'b0;
      r_fwd_rd        <= '0;
      r_fwd_val       <= '0;
    end else begin
      // Forwarding record is rewritten every edge so bubbles clear it.
      r_fwd_valid <= w_we;
      r_fwd_rd    <= w_we ? mem_rd : '0;
      r_fwd_val   <= w_we ? mem_regval : '0;
      if (w_retire) begin
        r_retired_count <= r_retired_count + 1'b1;
        r_last_pc       <= mem_pc;
        // The halt instruction itself retires before the state freezes.
        if (mem_is_halt)
          r_state <= S_HALTED;
      end
    end
  end

  assign retired_count = r_retired_count;
  assign last_pc       = r_last_pc;
  assign halted        = (r_state == S_HALTED);
  assign fwd_valid     = r_fwd_valid;
  assign fwd_rd        = r_fwd_rd;
  assign fwd_val       = r_fwd_val;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural model
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = '0;
  logic [5:0]  mem_op = '0;
  logic [31:0] mem_inst_count = '0;
  logic        mem_wr_reg = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_regval = '0;
  logic        mem_is_halt = 1'b0;
  logic [4:0]  rs1_idx = '0;
  logic [4:0]  rs2_idx = '0;
  logic [31:0] rs1_val, rs2_val;
  logic        wb_to_de_we;
  logic [4:0]  wb_to_de_rd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_val;
  logic [31:0] retired_count;
  logic        halted;
  logic [31:0] last_pc;

  // Narrow instance used to reach the counter wrap point in few cycles.
  logic        v8 = 1'b0;
  logic [7:0]  pc8 = '0;
  logic [7:0]  rs1_val8, rs2_val8, fwd_val8, retired_count8, last_pc8;
  logic        wb_to_de_we8, fwd_valid8, halted8;
  logic [4:0]  wb_to_de_rd8, fwd_rd8;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_count;
  logic [31:0] m_last_pc;
  logic        m_halted;
  logic        m_fwd_valid;
  logic [4:0]  m_fwd_rd;
  logic [31:0] m_fwd_val;

  wb_stage dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_op(mem_op), .mem_inst_count(mem_inst_count), .mem_wr_reg(mem_wr_reg),
    .mem_rd(mem_rd), .mem_regval(mem_regval), .mem_is_halt(mem_is_halt),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .wb_to_de_we(wb_to_de_we), .wb_to_de_rd(wb_to_de_rd), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_val(fwd_val), .retired_count(retired_count),
    .halted(halted), .last_pc(last_pc)
  );

  wb_stage #(.DBITS(8)) dut8 (
    .clk(clk), .reset(reset), .mem_valid(v8), .mem_pc(pc8),
    .mem_op(6'd0), .mem_inst_count(8'd0), .mem_wr_reg(1'b0),
    .mem_rd(5'd1), .mem_regval(8'hAA), .mem_is_halt(1'b0),
    .rs1_idx(5'd1), .rs2_idx(5'd2), .rs1_val(rs1_val8), .rs2_val(rs2_val8),
    .wb_to_de_we(wb_to_de_we8), .wb_to_de_rd(wb_to_de_rd8), .fwd_valid(fwd_valid8),
    .fwd_rd(fwd_rd8), .fwd_val(fwd_val8), .retired_count(retired_count8),
    .halted(halted8), .last_pc(last_pc8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_we();
    return mem_valid && mem_wr_reg && (mem_rd != 5'd0) && !m_halted;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (model_we() && idx == mem_rd) return mem_regval;
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_count = '0; m_last_pc = '0; m_halted = 1'b0;
    m_fwd_valid = 1'b0; m_fwd_rd = '0; m_fwd_val = '0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic wr,
                       input logic [4:0] rd, input logic [31:0] val, input logic hlt,
                       input logic [4:0] i1, input logic [4:0] i2);
    mem_valid = v; mem_pc = pc; mem_wr_reg = wr; mem_rd = rd; mem_regval = val;
    mem_is_halt = hlt; rs1_idx = i1; rs2_idx = i2;
    mem_op = 6'($urandom); mem_inst_count = $urandom;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic we, ret;
    #1;
    we = model_we();
    check("wb_to_de_we", {31'd0, wb_to_de_we}, {31'd0, we});
    if (we) check("wb_to_de_rd", {27'd0, wb_to_de_rd}, {27'd0, mem_rd});
    check("rs1_val", rs1_val, model_read(rs1_idx));
    check("rs2_val", rs2_val, model_read(rs2_idx));
    ret = mem_valid && !m_halted;
    @(posedge clk);
    m_fwd_valid = we;
    m_fwd_rd    = we ? mem_rd : 5'd0;
    m_fwd_val   = we ? mem_regval : 32'd0;
    if (we) m_rf[mem_rd] = mem_regval;
    if (ret) begin
      m_count   = m_count + 1;
      m_last_pc = mem_pc;
      if (mem_is_halt) m_halted = 1'b1;
    end
    #1;
    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fwd_valid});
    check("fwd_rd", {27'd0, fwd_rd}, {27'd0, m_fwd_rd});
    check("fwd_val", fwd_val, m_fwd_val);
    check("retired_count", retired_count, m_count);
    check("last_pc", last_pc, m_last_pc);
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_retired_count", retired_count, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_last_pc", last_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [4:0] rd;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Some activity, then reset mid-stream with a write pending on the edge
    drive(1, 32'h100, 1, 5'd9, 32'h5555_0001, 0, 5'd9, 5'd0); step();
    drive(1, 32'h104, 1, 5'd9, 32'h5555_0002, 0, 5'd9, 5'd0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst_retired_count", retired_count, 32'd0);
    check("midrst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("midrst_last_pc", last_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      rs1_idx = 5'(i);
      #1;
      check("rst_rf_read", rs1_val, 32'd0);
    end
    step();

    // Write-through bypass and next-cycle forwarding record
    drive(1, 32'h200, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd5); step();
    drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd0); step();
    check("rf5_holds", rs1_val, 32'hDEADBEEF);

    // Write to x0 is dropped but still retires
    drive(1, 32'h204, 1, 5'd0, 32'h1234, 0, 5'd0, 5'd5); step();

    // Three valid, two bubbles, one valid
    drive(1, 32'h300, 1, 5'd6, 32'h6, 0, 5'd6, 5'd7); step();
    drive(1, 32'h304, 1, 5'd7, 32'h7, 0, 5'd6, 5'd7); step();
    drive(1, 32'h308, 0, 5'd8, 32'h8, 0, 5'd8, 5'd7); step();
    drive(0, 32'h30C, 1, 5'd9, 32'h9, 0, 5'd9, 5'd6); step();
    drive(0, 32'h310, 1, 5'd9, 32'h9, 0, 5'd9, 5'd6); step();
    drive(1, 32'h314, 1, 5'd10, 32'hA, 0, 5'd10, 5'd6); step();
    check("seq_last_pc", last_pc, 32'h314);

    // Halt with a write, then writes that must be ignored
    drive(1, 32'h400, 1, 5'd3, 32'd7, 1, 5'd3, 5'd3); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h404 + 4 * i, 1, 5'd3, 32'h99 + i, 0, 5'd3, 5'd5); step();
    end
    check("halt_rf3", rs1_val, 32'd7);
    check("halt_flag", {31'd0, halted}, 32'd1);

    // Randomized traffic, with resets to clear halts
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        rd = 5'($urandom_range(0, 31));
        drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), rd, $urandom,
              $urandom_range(0, 99) == 0, $urandom_range(0, 1) ? rd : 5'($urandom),
              5'($urandom));
        step();
      end
    end

    // Counter wrap on the 8-bit instance: 255 retires then one more
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    v8 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      pc8 = 8'(i);
      @(negedge clk);
    end
    check("wrap_pre_count", {24'd0, retired_count8}, 32'd255);
    pc8 = 8'h5A;
    @(negedge clk);
    v8 = 1'b0;
    check("wrap_count", {24'd0, retired_count8}, 32'd0);
    check("wrap_last_pc", {24'd0, last_pc8}, 32'h5A);
    check("wrap_fwd_valid", {31'd0, fwd_valid8}, 32'd0);
    check("wrap_halted", {31'd0, halted8}, 32'd0);
    check("wrap_rf1", {24'd0, rs1_val8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
